// File: rtl/sia_receiver.sv
// ============================================================================
// Module   : sia_receiver
// Purpose  : SIA serial receive engine. Baud-timed over-sampling of rxd_i with
//            optional resync on data or receive-clock edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sia_receiver #(
  parameter int SHIFT_REG_WIDTH = 64,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [BITS_WIDTH-1:0]      bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       eedd_i,
  input  logic                       eedc_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  output logic                       idle_o,
  output logic                       sample_to
);

  logic                       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic                       rxc_meta_q, rxc_sync_q, rxc_prev_q;
  logic [SHIFT_REG_WIDTH-1:0] dat_q, dat_d;
  logic [BAUD_RATE_WIDTH-1:0] timer_q, timer_d;
  logic [BITS_WIDTH-1:0]      bits_q, bits_d;
  logic                       sample_q, sample_d;

  logic rxd_fall, rxd_edge, rxc_rise, resync, idle;

  assign rxd_fall = rxd_prev_q & ~rxd_sync_q;
  assign rxd_edge = rxd_prev_q ^ rxd_sync_q;
  assign rxc_rise = ~rxc_prev_q & rxc_sync_q;
  assign resync   = (eedd_i & rxd_edge) | (eedc_i & rxc_rise);
  assign idle     = (bits_q == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rxc_meta_q <= 1'b0;
      rxc_sync_q <= 1'b0;
      rxc_prev_q <= 1'b0;
      dat_q      <= '1;
      timer_q    <= '0;
      bits_q     <= '0;
      sample_q   <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rxc_meta_q <= rxc_i;
      rxc_sync_q <= rxc_meta_q;
      rxc_prev_q <= rxc_sync_q;
      dat_q      <= dat_d;
      timer_q    <= timer_d;
      bits_q     <= bits_d;
      sample_q   <= sample_d;
    end
  end

  always_comb begin
    dat_d    = dat_q;
    timer_d  = timer_q;
    bits_d   = bits_q;
    sample_d = 1'b0;
    if (idle) begin
      if (rxd_fall && (bits_i != '0)) begin
        bits_d  = bits_i;
        timer_d = baud_i >> 1;
      end
    end else begin
      if (timer_q == '0) begin
        sample_d = 1'b1;
        dat_d    = {rxd_sync_q, dat_q[SHIFT_REG_WIDTH-1:1]};
        bits_d   = bits_q - {{(BITS_WIDTH-1){1'b0}}, 1'b1};
        timer_d  = baud_i;
      end else begin
        timer_d  = timer_q - {{(BAUD_RATE_WIDTH-1){1'b0}}, 1'b1};
      end
      // A resync edge wins the timer reload even when a sample is taken.
      if (resync) begin
        timer_d = baud_i >> 1;
      end
    end
  end

  assign dat_o     = dat_q;
  assign idle_o    = idle;
  assign sample_to = sample_q;

endmodule

`default_nettype wire

// File: tb/tb_sia_receiver.sv
// ============================================================================
// Module   : tb_sia_receiver
// Purpose  : Self-checking scoreboard bench for sia_receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sia_receiver;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [4:0]  bits_i = 5'd11;
  logic [31:0] baud_i = 32'd49;
  logic        eedd_i = 1'b1;
  logic        eedc_i = 1'b1;
  logic        rxd_i = 1'b1;
  logic        rxc_i = 1'b0;
  logic [63:0] dat_o;
  logic        idle_o;
  logic        sample_to;

  sia_receiver #(
    .SHIFT_REG_WIDTH(64),
    .BAUD_RATE_WIDTH(32),
    .BITS_WIDTH(5)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .bits_i   (bits_i),
    .baud_i   (baud_i),
    .eedd_i   (eedd_i),
    .eedc_i   (eedc_i),
    .rxd_i    (rxd_i),
    .rxc_i    (rxc_i),
    .dat_o    (dat_o),
    .idle_o   (idle_o),
    .sample_to(sample_to)
  );

  always #10 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] cyc = '0;
  int          smp_cnt = 0;
  bit          mon_en = 1'b0;

  logic [63:0] exp_dat_q[$];
  logic [63:0] exp_idle_q[$];
  logic [63:0] exp_smp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 64'd1;

  // Every sample pulse is matched against the cycle the scoreboard predicted.
  always @(negedge clk_i) begin
    if (sample_to) begin
      smp_cnt++;
      if (mon_en) begin
        check_val("sample_cyc", cyc, (exp_smp_q.size() != 0) ? exp_smp_q.pop_front() : '1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    rxd_i   = 1'b1;
    rxc_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("rst_idle", idle_o, 64'd1);
    check_val("rst_dat", dat_o, '1);
    reset_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic run_timing(input bit toggle_rxc);
    logic [63:0] c0;
    do_reset();
    eedd_i = 1'b0;
    eedc_i = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_i);
    c0    = cyc;
    rxd_i = 1'b0;
    for (int i = 0; i < 11; i++) exp_smp_q.push_back(c0 + 64'd28 + 64'd50 * 64'(i));
    for (int j = 1; j <= 620; j++) begin
      @(negedge clk_i);
      if (toggle_rxc && (j % 17 == 0)) rxc_i = ~rxc_i;
    end
    check_val(toggle_rxc ? "tog_idle" : "tim_idle", idle_o, 64'd1);
    check_val(toggle_rxc ? "tog_missing" : "tim_missing", 64'(exp_smp_q.size()), 64'd0);
    exp_smp_q.delete();
    mon_en = 1'b0;
    rxd_i  = 1'b1;
    rxc_i  = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        seq [12];
    logic [63:0] model;
    int          start_cnt;

    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Asynchronous frame with data/clock resync enabled, plus a second frame start
    do_reset();
    bits_i = 5'd11;
    baud_i = 32'd49;
    eedd_i = 1'b1;
    eedc_i = 1'b1;
    model  = '1;
    for (int k = 0; k < 12; k++) begin
      rxd_i = seq[k];
      model = {seq[k], model[63:1]};
      exp_dat_q.push_back(model);
      exp_idle_q.push_back((k == 10) ? 64'd1 : 64'd0);
      repeat (50) @(negedge clk_i);
      check_val("async_dat", dat_o, exp_dat_q.pop_front());
      check_val("async_idle", idle_o, exp_idle_q.pop_front());
    end
    check_val("async_top12", {52'd0, dat_o[63:52]}, 64'h50A);

    // Receive-clock driven mode with rxd held low
    do_reset();
    eedd_i = 1'b1;
    eedc_i = 1'b1;
    model  = '1;
    for (int n = 1; n <= 11; n++) begin
      rxd_i = 1'b0;
      rxc_i = 1'b1;
      model = {1'b0, model[63:1]};
      exp_dat_q.push_back(model);
      exp_idle_q.push_back((n == 11) ? 64'd1 : 64'd0);
      repeat (25) @(negedge clk_i);
      rxc_i = 1'b0;
      repeat (25) @(negedge clk_i);
      check_val("clk_dat", dat_o, exp_dat_q.pop_front());
      check_val("clk_idle", idle_o, exp_idle_q.pop_front());
    end

    run_timing(1'b0);
    run_timing(1'b1);

    // Asynchronous reset in the middle of a frame
    do_reset();
    eedd_i    = 1'b1;
    eedc_i    = 1'b1;
    start_cnt = smp_cnt;
    rxd_i     = 1'b0;
    for (int j = 0; j < 400 && (smp_cnt - start_cnt) < 3; j++) @(negedge clk_i);
    check_val("mid_samples", 64'(smp_cnt - start_cnt), 64'd3);
    check_val("mid_dat_pre", dat_o, {3'b000, {61{1'b1}}});
    check_val("mid_idle_pre", idle_o, 64'd0);
    #3;
    reset_i = 1'b1;
    #1;
    check_val("mid_rst_idle", idle_o, 64'd1);
    check_val("mid_rst_dat", dat_o, '1);
    rxd_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
